// File: rtl/multi_port_rom_pipelined_pkg.sv
// Shared ROM contents and configuration limits for the multi-port pipelined ROM.
// Every read port builds its constant table from rom_word(), so all ports
// return the same contents by construction.
package rom_pkg;

    // Legal configuration ranges
    localparam int unsigned DATA_W_MIN   = 8;
    localparam int unsigned DATA_W_MAX   = 128;
    localparam int unsigned DEPTH_MIN    = 2;
    localparam int unsigned DEPTH_MAX    = 256;
    localparam int unsigned PORTS_MIN    = 1;
    localparam int unsigned PORTS_MAX    = 4;
    localparam int unsigned PIPE_MIN     = 1;
    localparam int unsigned PIPE_MAX     = 4;

    // Widest word rom_word() can produce; callers keep the low DATA_W bits
    localparam int unsigned WORD_MAX_W   = 128;
    localparam int unsigned BASE_COUNT   = 8;

    // Base pattern table; word i of a ROM uses entry (i mod 8)
    localparam logic [63:0] BASE_WORDS [BASE_COUNT] = '{
        64'h5B5B5B5B5B5B5B5B,
        64'hAE6A4719E7B99682,
        64'h7631CF8A8ACF3176,
        64'h8AE782B9477E1996,
        64'h5BA5A55B5BA5A55B,
        64'h4782196A96E77EB9,
        64'h918A76CFCF768A31,
        64'h19B96A827E9647E7
    };

    // Word i: base word (i mod 8), XOR-ed with i replicated in every byte
    // once the index wraps past the base table, limited to dw bits.
    function automatic logic [WORD_MAX_W-1:0] rom_word(input int unsigned i,
                                                       input int unsigned dw);
        logic [WORD_MAX_W-1:0] word;
        logic [7:0]            idx_byte;
        word     = {64'b0, BASE_WORDS[i % BASE_COUNT]};
        idx_byte = 8'(i);
        if (i >= BASE_COUNT) begin
            for (int b = 0; b < WORD_MAX_W / 8; b++) begin
                word[b*8 +: 8] = word[b*8 +: 8] ^ idx_byte;
            end
        end
        for (int k = 0; k < WORD_MAX_W; k++) begin
            if (k >= int'(dw)) begin
                word[k] = 1'b0;
            end
        end
        return word;
    endfunction

    // True when a parameter set lies inside the supported ranges
    function automatic bit cfg_ok(input int unsigned data_w, input int unsigned depth,
                                  input int unsigned ports, input int unsigned stages);
        return (data_w >= DATA_W_MIN) && (data_w <= DATA_W_MAX) &&
               (depth  >= DEPTH_MIN)  && (depth  <= DEPTH_MAX)  &&
               (ports  >= PORTS_MIN)  && (ports  <= PORTS_MAX)  &&
               (stages >= PIPE_MIN)   && (stages <= PIPE_MAX);
    endfunction

endpackage

// File: rtl/multi_port_rom_pipelined_read_pipe.sv
// One read port: combinational address decode into the constant table, then a
// PIPE_STAGES-deep register chain carrying valid, data and the range error.
// Invalid slots travel as all-zero so stale data never reaches the outputs.
module rom_read_pipe
    import rom_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned PIPE_STAGES = 2,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req_valid,
    input  logic [AW-1:0]     addr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err
);

    localparam int unsigned ROM_SLOTS = 2 ** AW;
    localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

    // Table covers the full address space; slots past DEPTH read as zero
    logic [DATA_W-1:0] rom [ROM_SLOTS];

    for (genvar i = 0; i < ROM_SLOTS; i++) begin : g_rom
        if (i < DEPTH) begin : g_word
            localparam logic [WORD_MAX_W-1:0] WORD = rom_word(i, DATA_W);
            assign rom[i] = WORD[DATA_W-1:0];
        end else begin : g_pad
            assign rom[i] = '0;
        end
    end

    logic              in_range;
    logic              dec_vld;
    logic [DATA_W-1:0] dec_data;
    logic              dec_err;

    assign in_range = ({1'b0, addr} < DEPTH_EXT);

    // Decode ahead of the first register: valid request in range returns the word
    always_comb begin
        dec_vld  = 1'b0;
        dec_data = '0;
        dec_err  = 1'b0;
        if (req_valid) begin
            dec_vld = 1'b1;
            if (in_range) begin
                dec_data = rom[addr];
            end else begin
                dec_err  = 1'b1;
            end
        end
    end

    logic              vld_p  [PIPE_STAGES];
    logic [DATA_W-1:0] data_p [PIPE_STAGES];
    logic              err_p  [PIPE_STAGES];

    // Stage registers: reset clears everything, en=0 freezes the whole chain
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                vld_p[s]  <= 1'b0;
                data_p[s] <= '0;
                err_p[s]  <= 1'b0;
            end
        end else if (en) begin
            // stage 0: capture decoded word
            vld_p[0]  <= dec_vld;
            data_p[0] <= dec_data;
            err_p[0]  <= dec_err;
            // stages 1..PIPE_STAGES-1: plain delay
            for (int s = 1; s < PIPE_STAGES; s++) begin
                vld_p[s]  <= vld_p[s-1];
                data_p[s] <= data_p[s-1];
                err_p[s]  <= err_p[s-1];
            end
        end
    end

    assign rsp_valid = vld_p[PIPE_STAGES-1];
    assign rsp_data  = data_p[PIPE_STAGES-1];
    assign rsp_err   = err_p[PIPE_STAGES-1];

endmodule

// File: rtl/multi_port_rom_pipelined.sv
// Multi-port pipelined ROM: NUM_PORTS independent read pipes sharing one
// constant table definition, a common enable and a common reset.
module multi_port_rom_pipelined
    import rom_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned PIPE_STAGES = 2,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [NUM_PORTS-1:0]        req_valid,
    input  logic [NUM_PORTS*AW-1:0]     addr,
    output logic [NUM_PORTS-1:0]        rsp_valid,
    output logic [NUM_PORTS*DATA_W-1:0] rsp_data,
    output logic [NUM_PORTS-1:0]        rsp_err
);

    localparam bit CFG_OK = cfg_ok(DATA_W, DEPTH, NUM_PORTS, PIPE_STAGES);

    if (!CFG_OK) begin : g_bad_cfg
        $error("multi_port_rom_pipelined: parameter set outside supported range");
    end

    // No shared state between ports, so there is nothing to arbitrate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        rom_read_pipe #(
            .DATA_W      (DATA_W),
            .DEPTH       (DEPTH),
            .PIPE_STAGES (PIPE_STAGES)
        ) u_pipe (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .req_valid (req_valid[p]),
            .addr      (addr[p*AW +: AW]),
            .rsp_valid (rsp_valid[p]),
            .rsp_data  (rsp_data[p*DATA_W +: DATA_W]),
            .rsp_err   (rsp_err[p])
        );
    end

endmodule

// File: tb/tb_multi_port_rom_pipelined.sv
// Scoreboard bench: the driver pushes hand-computed responses per port as it
// issues requests; a monitor pops and compares whenever the outputs advance.
module tb_multi_port_rom_pipelined;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 10;
    localparam int NP     = 2;
    localparam int PS     = 2;
    localparam int AW     = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic [NP-1:0]          req_valid;
    logic [NP*AW-1:0]       addr;
    logic [NP-1:0]          rsp_valid;
    logic [NP*DATA_W-1:0]   rsp_data;
    logic [NP-1:0]          rsp_err;

    always #5 clk = ~clk;

    multi_port_rom_pipelined #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .NUM_PORTS   (NP),
        .PIPE_STAGES (PS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .addr      (addr),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int vec_cnt  = 0;
    int miscmp   = 0;
    int adv_cnt  = 0;

    // Hand-computed words for a DEPTH=10 ROM (8 and 9 carry the index XOR)
    logic [63:0] exp_tab [10] = '{
        64'h5B5B5B5B5B5B5B5B,
        64'hAE6A4719E7B99682,
        64'h7631CF8A8ACF3176,
        64'h8AE782B9477E1996,
        64'h5BA5A55B5BA5A55B,
        64'h4782196A96E77EB9,
        64'h918A76CFCF768A31,
        64'h19B96A827E9647E7,
        64'h5353535353535353,
        64'hA7634E10EEB09F8B
    };

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vec_cnt++;
        if (act !== req) begin
            miscmp++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input int a, input int due);
        exp_t e;
        if (a >= DEPTH) begin
            e.data = '0;
            e.err  = 1'b1;
        end else begin
            e.data = exp_tab[a];
            e.err  = 1'b0;
        end
        e.due = due;
        return e;
    endfunction

    task automatic drive(input bit e, input bit v0, input int a0, input bit v1, input int a1);
        logic [3:0] s0, s1;
        s0 = a0[3:0];
        s1 = a1[3:0];
        en        = e;
        req_valid = {v1, v0};
        addr      = {s1, s0};
        if (e) begin
            if (v0) q0.push_back(mk(a0, adv_cnt + PS));
            if (v1) q1.push_back(mk(a1, adv_cnt + PS));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cycle(input bit e, input bit v, input int a);
        logic [3:0] s;
        s = a[3:0];
        rst       = 1'b1;
        en        = e;
        req_valid = {v, v};
        addr      = {s, s};
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic port_check(input int p);
        exp_t        e;
        bit          have;
        logic [63:0] d;
        d = rsp_data[p*DATA_W +: DATA_W];
        if (rsp_valid[p]) begin
            have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
            vec_cnt++;
            if (!have) begin
                miscmp++;
                $display("FAIL unexpected_rsp port%0d: got data %h, expected no response", p, d);
            end else begin
                e = (p == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("data port%0d", p), d, e.data);
                check($sformatf("err port%0d", p), 64'(rsp_err[p]), 64'(e.err));
                check($sformatf("latency port%0d", p), 64'(adv_cnt), 64'(e.due));
            end
        end else begin
            check($sformatf("idle_data port%0d", p), d, 64'h0);
            check($sformatf("idle_err port%0d", p), 64'(rsp_err[p]), 64'h0);
        end
    endtask

    // Monitor: sample control at the edge, compare at the following falling edge
    initial begin
        logic [NP-1:0]        pv;
        logic [NP*DATA_W-1:0] pd;
        logic [NP-1:0]        pe;
        bit                   was_rst;
        bit                   adv;
        pv = '0;
        pd = '0;
        pe = '0;
        forever begin
            @(posedge clk);
            was_rst = (rst === 1'b1);
            adv     = (en === 1'b1) && !was_rst;
            if (was_rst) begin
                q0.delete();
                q1.delete();
            end else if (adv) begin
                adv_cnt++;
            end
            @(negedge clk);
            if (was_rst) begin
                check("reset rsp_valid", 64'(rsp_valid), 64'h0);
                check("reset rsp_err", 64'(rsp_err), 64'h0);
                check("reset rsp_data0", rsp_data[63:0], 64'h0);
                check("reset rsp_data1", rsp_data[127:64], 64'h0);
            end else if (!adv) begin
                check("stall rsp_valid", 64'(rsp_valid), 64'(pv));
                check("stall rsp_err", 64'(rsp_err), 64'(pe));
                check("stall rsp_data0", rsp_data[63:0], pd[63:0]);
                check("stall rsp_data1", rsp_data[127:64], pd[127:64]);
            end else begin
                for (int p = 0; p < NP; p++) port_check(p);
            end
            pv = rsp_valid;
            pd = rsp_data;
            pe = rsp_err;
        end
    end

    // Stimulus
    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        req_valid = '0;
        addr      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // two ports, different words
        drive(1, 1, 1, 1, 6);
        // back-to-back sweep, port1 in reverse order
        for (int a = 0; a < 8; a++) drive(1, 1, a, 1, 7 - a);
        // wrapped words, out-of-range, mixed valid, same address on both ports
        drive(1, 1, 8, 1, 9);
        drive(1, 1, 12, 1, 15);
        drive(1, 1, 9, 0, 3);
        drive(1, 1, 4, 1, 4);
        drive(1, 0, 0, 1, 2);
        repeat (3) drive(1, 0, 0, 0, 0);

        // stall with the request still in flight; stalled inputs are ignored
        drive(1, 1, 3, 0, 0);
        repeat (3) drive(0, 1, 5, 1, 5);
        repeat (3) drive(1, 0, 0, 0, 0);

        // stall while a response is being shown
        drive(1, 1, 2, 1, 1);
        drive(1, 0, 0, 0, 0);
        repeat (2) drive(0, 1, 7, 1, 7);
        repeat (3) drive(1, 0, 0, 0, 0);

        // reset one cycle after a request: it must never emerge
        drive(1, 1, 3, 1, 5);
        rst_cycle(1, 1, 7);
        drive(1, 1, 0, 1, 9);
        repeat (3) drive(1, 0, 0, 0, 0);

        // reset wins over en=0
        drive(1, 1, 6, 1, 6);
        drive(0, 0, 0, 0, 0);
        rst_cycle(0, 0, 0);
        drive(1, 1, 2, 1, 11);
        repeat (3) drive(1, 0, 0, 0, 0);

        // mixed traffic with random enable gaps
        for (int c = 0; c < 150; c++) begin
            drive(($urandom % 4) != 0, $urandom % 2 == 1, int'($urandom_range(0, 15)),
                  $urandom % 2 == 1, int'($urandom_range(0, 15)));
        end

        // bounded drain, then everything issued must have been answered
        repeat (8) drive(1, 0, 0, 0, 0);
        check("drain q0", 64'(q0.size()), 64'h0);
        check("drain q1", 64'(q1.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule

// File: doc/multi_port_rom_pipelined.md
MULTI_PORT_ROM_PIPELINED -- requirements
Module: multi_port_rom_pipelined

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter DATA_W, default 64: word width in bits (8..128).
REQ-003 Parameter DEPTH, default 8: number of ROM words (2..256, not necessarily a power of two).
REQ-004 Parameter NUM_PORTS, default 2: independent read ports (1..4).
REQ-005 Parameter PIPE_STAGES, default 2: read latency in cycles (1..4).
REQ-006 Localparam AW SHALL equal $clog2(DEPTH).
REQ-007 Port clk, input, 1 bit: rising-edge clock.
REQ-008 Port rst, input, 1 bit: synchronous active-high reset.
REQ-009 Port en, input, 1 bit: global advance enable; 0 stalls every pipeline stage.
REQ-010 Port req_valid, input, NUM_PORTS bits: per-port read request.
REQ-011 Port addr, input, NUM_PORTS*AW bits: port p address in slice [p*AW +: AW].
REQ-012 Port rsp_valid, output, NUM_PORTS bits: per-port response valid.
REQ-013 Port rsp_data, output, NUM_PORTS*DATA_W bits: port p data in slice [p*DATA_W +: DATA_W].
REQ-014 Port rsp_err, output, NUM_PORTS bits: per-port out-of-range flag, qualified by rsp_valid.

Function
REQ-015 ROM word i SHALL be the package function rom_word(i, DATA_W), which returns the low DATA_W bits of base word (i mod 8), XOR-ed with i replicated bytewise when i >= 8.
REQ-016 Base words 0..7 SHALL be 5B5B5B5B5B5B5B5B, AE6A4719E7B99682, 7631CF8A8ACF3176, 8AE782B9477E1996, 5BA5A55B5BA5A55B, 4782196A96E77EB9, 918A76CFCF768A31 and 19B96A827E9647E7 (hex).
REQ-017 With en=1, a request accepted at edge N SHALL appear on rsp_valid/rsp_data/rsp_err after edge N+PIPE_STAGES-1, i.e. PIPE_STAGES cycles after the address is presented.
REQ-018 The pipeline SHALL accept one request per port per cycle with en=1, giving full throughput and no bubbles.
REQ-019 When en=0, all stage registers SHALL hold, outputs SHALL remain unchanged, and req_valid/addr SHALL be ignored; nothing SHALL be dropped or duplicated.
REQ-020 If addr >= DEPTH, the response SHALL be rsp_err=1 with rsp_data=0.
REQ-021 If req_valid=0, that slot SHALL propagate as rsp_valid=0, with rsp_data=0 and rsp_err=0; stale data SHALL NOT be shown.
REQ-022 Ports SHALL be fully independent: the same address on several ports in the same cycle SHALL return identical data on each, with no arbitration.
REQ-023 Address decode SHALL be combinational before stage 1; stages 2..PIPE_STAGES SHALL be pure registers.

Reset
REQ-024 rst=1 at a rising edge SHALL clear every stage, so that rsp_valid=0, rsp_data=0 and rsp_err=0 on the following cycle.
REQ-025 rst SHALL take priority over en.
REQ-026 In-flight requests at reset SHALL be discarded; the first post-reset response SHALL come from a request presented after rst deasserts.

Structure
REQ-027 rom_word(), the base-word constant array and the range limits SHALL live in package rom_pkg.
REQ-028 One sub-module, rom_read_pipe, SHALL implement a single port's decode plus PIPE_STAGES-deep valid/data/err pipeline with en and rst; the top SHALL instantiate it NUM_PORTS times via generate.
REQ-029 Synthesis SHALL infer no tri-state or latch; ROM storage SHALL be LUT/constant logic.

Verification
REQ-030 Defaults, reset then en=1, port0 addr=1 and port1 addr=6, both valid -> 2 cycles later AE6A4719E7B99682 and 918A76CFCF768A31, rsp_valid=11, rsp_err=00.
REQ-031 Back-to-back addr 0..7 on port0 for 8 cycles -> 8 consecutive valid responses matching REQ-016 in order, with no gaps.
REQ-032 DEPTH=10, DATA_W=64, addr=9 -> data AE6A4719E7B99682 XOR 0909090909090909; addr=12 -> rsp_err=1, data 0.
REQ-033 A request at addr 3, then en=0 for 3 cycles, then en=1 -> rsp_valid held/stalled with no duplicate; exactly one response of 8AE782B9477E1996.
REQ-034 rst asserted 1 cycle after a request with PIPE_STAGES=3 -> no response ever emerges for it, and outputs are 0 the cycle after rst.
REQ-035 PIPE_STAGES=1 and 4 sweep, random addr/valid/en for 10k cycles on NUM_PORTS=4 -> the scoreboard matches the reference model with latency exactly PIPE_STAGES enabled cycles.
